// File: rtl/obi_mem_responder_if.sv
// OBI request/response bundle for one channel (instruction fetch or data).
// Master drives req/addr/we/be/wdata; slave drives gnt/rvalid/rdata/err.
// Slave asserts gnt while the master holds req; responses have no ready.
interface obi_mem_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;     // request valid; attributes stable until gnt
    logic            gnt;     // accept = req & gnt
    logic [AW-1:0]   addr;    // byte address
    logic            we;      // 1 = write
    logic [DW/8-1:0] be;      // byte enables (writes)
    logic [DW-1:0]   wdata;   // write data
    logic            rvalid;  // one response cycle per accept
    logic [DW-1:0]   rdata;   // read data, 0 for writes/errors/idle
    logic            err;     // response error, qualified by rvalid

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_mem_responder.sv
// OBI memory slave model with backing RAM, grant stall, fixed response latency, outstanding limit.
// Latency: accept in cycle N -> rvalid in cycle N+RESP_LAT; gnt is combinational on req.
// Backpressure: gnt withheld during stall count or when MAX_OUT outstanding without a draining rvalid.
// Ports: clk_i/rst_i (async active-high), bus (slave modport: req/gnt/addr/we/be/wdata/rvalid/rdata/err),
//        outstanding_o (accepted-but-unanswered count).
// Optional feature: define OBI_RAND_STALL_EN to add an LFSR-driven pseudo-random grant mask.
module obi_mem_responder #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            DEPTH     = 1024,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int            GNT_STALL = 0,
    parameter int            RESP_LAT  = 1,
    parameter int            MAX_OUT   = 2,
    parameter logic [15:0]   LFSR_SEED = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    obi_mem_responder_if.slave           bus,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o
);
    localparam int OFFB = $clog2(DW/8);
    localparam int IW   = $clog2(DEPTH);
    localparam int OW   = $clog2(MAX_OUT+1);
    localparam int NB   = DW/8;

    localparam logic [OW-1:0] MAX_OUT_V = OW'(MAX_OUT);
    localparam logic [3:0]    STALL_V   = 4'(GNT_STALL);
    localparam logic [AW-1:0] DEPTH_V   = AW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [3:0]          stall_cnt_q, stall_cnt_d;
    logic [OW-1:0]       outstanding_q, outstanding_d;
    logic [RESP_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RESP_LAT-1:0] pipe_err_q, pipe_err_d;
    logic [DW-1:0]       pipe_dat_q [RESP_LAT];
    logic [DW-1:0]       pipe_dat_d [RESP_LAT];

    logic [AW-1:0] offset;
    logic [AW-1:0] idx_full;
    logic [IW-1:0] idx;
    logic          in_range;
    logic          rvalid;
    logic          gnt;
    logic          lfsr_ok;

`ifdef OBI_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
`endif

    always_comb begin
        // Address decode: the full-width index is compared against DEPTH so
        // addresses beyond the array report an error instead of aliasing.
        offset   = bus.addr - BASE_ADDR;
        idx_full = offset >> OFFB;
        in_range = (bus.addr >= BASE_ADDR) && (idx_full < DEPTH_V);
        idx      = idx_full[IW-1:0];

        rvalid = pipe_vld_q[RESP_LAT-1];

`ifdef OBI_RAND_STALL_EN
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        lfsr_ok = (lfsr_q[1:0] != 2'b00);
`else
        lfsr_ok = 1'b1;
`endif

        // A full pipeline may still accept when a response leaves this cycle.
        gnt = bus.req && !rst_i && (stall_cnt_q == 4'd0) && lfsr_ok &&
              ((outstanding_q < MAX_OUT_V) || rvalid);

        if (!bus.req || gnt) begin
            stall_cnt_d = STALL_V;
        end else if (stall_cnt_q != 4'd0) begin
            stall_cnt_d = stall_cnt_q - 4'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        outstanding_d = outstanding_q;
        if (gnt && !rvalid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!gnt && rvalid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        // Stage 0 captures the response at the accept edge; data stays zero
        // for empty slots so the output needs no extra masking.
        pipe_vld_d = '0;
        pipe_err_d = '0;
        for (int i = 0; i < RESP_LAT; i++) begin
            pipe_dat_d[i] = '0;
        end
        pipe_vld_d[0] = gnt;
        pipe_err_d[0] = gnt && !in_range;
        pipe_dat_d[0] = (gnt && !bus.we && in_range) ? mem[idx] : '0;
        for (int i = 1; i < RESP_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_err_d[i] = pipe_err_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q   <= STALL_V;
            outstanding_q <= '0;
            pipe_vld_q    <= '0;
            pipe_err_q    <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                pipe_dat_q[i] <= '0;
            end
`ifdef OBI_RAND_STALL_EN
            lfsr_q <= LFSR_SEED;
`endif
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            outstanding_q <= outstanding_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_err_q    <= pipe_err_d;
            for (int i = 0; i < RESP_LAT; i++) begin
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
`ifdef OBI_RAND_STALL_EN
            lfsr_q <= lfsr_d;
`endif
        end
    end

    // Memory has no reset; gnt is already masked during reset.
    always_ff @(posedge clk_i) begin
        if (gnt && bus.we && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.be[b]) begin
                    mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rvalid;
    assign bus.rdata     = pipe_dat_q[RESP_LAT-1];
    assign bus.err       = pipe_err_q[RESP_LAT-1];
    assign outstanding_o = outstanding_q;
endmodule

// File: tb/tb_obi_mem_responder.sv
module tb_obi_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    obi_mem_responder_if #(.AW(32), .DW(32)) bus_a (), bus_s (), bus_p ();
    logic [0:0] out_a, out_s;
    logic [1:0] out_p;

    obi_mem_responder #(.AW(32), .DW(32), .DEPTH(1024), .BASE_ADDR(32'h0),
                        .GNT_STALL(0), .RESP_LAT(1), .MAX_OUT(1), .LFSR_SEED(16'hACE1))
        u_a (.clk_i(clk), .rst_i(rst), .bus(bus_a), .outstanding_o(out_a));
    obi_mem_responder #(.AW(32), .DW(32), .DEPTH(1024), .BASE_ADDR(32'h0),
                        .GNT_STALL(3), .RESP_LAT(1), .MAX_OUT(1), .LFSR_SEED(16'hACE1))
        u_s (.clk_i(clk), .rst_i(rst), .bus(bus_s), .outstanding_o(out_s));
    obi_mem_responder #(.AW(32), .DW(32), .DEPTH(1024), .BASE_ADDR(32'h0),
                        .GNT_STALL(0), .RESP_LAT(4), .MAX_OUT(2), .LFSR_SEED(16'hACE1))
        u_p (.clk_i(clk), .rst_i(rst), .bus(bus_p), .outstanding_o(out_p));

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_p[$];
    int   p_rv_cnt = 0;
    int   p_peak   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
        end
    endtask

    // Response monitors: pop expected entries whenever rvalid is seen.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus_a.rvalid) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_rdata", bus_a.rdata, e.dat);
                    chk("a_err", {31'd0, bus_a.err}, {31'd0, e.err});
                    chk("a_rvalid_cycle", cyc_cnt, e.cyc);
                end
            end else begin
                chk("a_idle_outputs", bus_a.rdata | {31'd0, bus_a.err}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (int'(out_p) > p_peak) p_peak = int'(out_p);
        if (bus_p.rvalid) begin
            p_rv_cnt++;
            if (q_p.size() == 0) begin
                chk("p_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = q_p.pop_front();
                chk("p_rdata", bus_p.rdata, e.dat);
                chk("p_err", {31'd0, bus_p.err}, {31'd0, e.err});
                chk("p_rvalid_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    // Called at posedge+1; returns at a later posedge+1 with req dropped.
    task automatic a_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_dat, input logic exp_err);
        int n;
        bus_a.req = 1'b1; bus_a.we = we; bus_a.addr = addr; bus_a.be = be; bus_a.wdata = wd;
        #1;
        chk("a_gnt_first_cycle", {31'd0, bus_a.gnt}, 32'd1);
        n = 0;
        while (!bus_a.gnt && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (bus_a.gnt) q_a.push_back('{dat: exp_dat, err: exp_err, cyc: cyc_cnt + 1});
        else chk("a_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.be = '0; bus_a.wdata = '0;
    endtask

    // Directed vectors for the LAT=1 instance: {we, addr, be, wdata, exp rdata, exp err}
    logic        a_we  [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
    logic [31:0] a_adr [12] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h20, 32'h13,
                                32'h0, 32'hFFC, 32'hFFC, 32'h1000, 32'h1000, 32'h0};
    logic [3:0]  a_be  [12] = '{4'hF, 4'h0, 4'hF, 4'b0101, 4'h0, 4'h0,
                                4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    logic [31:0] a_wd  [12] = '{32'hCAFEBABE, 32'h0, 32'h11223344, 32'hAABBCCDD, 32'h0, 32'h0,
                                32'h12345678, 32'h5A5A5A5A, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] a_rd  [12] = '{32'h0, 32'hCAFEBABE, 32'h0, 32'h0, 32'h11BB33DD, 32'hCAFEBABE,
                                32'h0, 32'h0, 32'h5A5A5A5A, 32'h0, 32'h0, 32'h12345678};
    logic        a_er  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

    // Pipelined instance: three writes then three reads, req held throughout.
    logic        p_we  [6] = '{1, 1, 1, 0, 0, 0};
    logic [31:0] p_adr [6] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    logic [31:0] p_wd  [6] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h0, 32'h0, 32'h0};
    logic [31:0] p_rd  [6] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222, 32'h33333333};
    int          p_out [10] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2};

    initial begin
        logic [15:0] s_req_pat;
        logic [15:0] s_gnt_pat;
        logic [9:0]  p_gnt_pat;
        int tx;
        int rv_before;
        s_req_pat = 16'h7AFF;
        s_gnt_pat = 16'h4088;
        p_gnt_pat = 10'h333;

        bus_a.req = 1'b1; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.be = '0; bus_a.wdata = '0;
        bus_s.req = 1'b1; bus_s.we = 1'b0; bus_s.addr = '0; bus_s.be = '0; bus_s.wdata = '0;
        bus_p.req = 1'b1; bus_p.we = 1'b0; bus_p.addr = '0; bus_p.be = '0; bus_p.wdata = '0;

        // Reset held with requests pending: nothing may be granted or answered.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("rst_gnt_a", {31'd0, bus_a.gnt}, 32'd0);
            chk("rst_rvalid_a", {31'd0, bus_a.rvalid}, 32'd0);
            chk("rst_out_a", {31'd0, out_a}, 32'd0);
            chk("rst_gnt_p", {31'd0, bus_p.gnt}, 32'd0);
            chk("rst_out_p", {30'd0, out_p}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.req = 1'b0; bus_s.req = 1'b0; bus_p.req = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            a_xfer(a_we[i], a_adr[i], a_be[i], a_wd[i], a_rd[i], a_er[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("a_all_responses", q_a.size(), 32'd0);

        // Grant stall counting, including restarts on req drop.
        for (int i = 0; i < 16; i++) begin
            bus_s.req = s_req_pat[i];
            #1;
            chk($sformatf("s_gnt_c%0d", i), {31'd0, bus_s.gnt}, {31'd0, s_gnt_pat[i]});
            @(posedge clk); #1;
        end
        bus_s.req = 1'b0;

        // Outstanding limit with req held continuously.
        tx = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx < 6) begin
                bus_p.we = p_we[tx]; bus_p.addr = p_adr[tx];
                bus_p.be = 4'hF;     bus_p.wdata = p_wd[tx];
            end
            bus_p.req = 1'b1;
            #1;
            chk($sformatf("p_gnt_c%0d", c), {31'd0, bus_p.gnt}, {31'd0, p_gnt_pat[c]});
            chk($sformatf("p_out_c%0d", c), {30'd0, out_p}, p_out[c]);
            if (bus_p.gnt && tx < 6) begin
                q_p.push_back('{dat: p_rd[tx], err: 1'b0, cyc: cyc_cnt + 4});
                tx++;
            end
            @(posedge clk); #1;
        end
        bus_p.req = 1'b0; bus_p.we = 1'b0;
        chk("p_all_accepted", tx, 32'd6);
        repeat (8) @(posedge clk);
        #1;
        chk("p_all_responses", q_p.size(), 32'd0);
        chk("p_out_peak", p_peak, 32'd2);

        // Reset while a read is in flight: its response must never appear.
        bus_p.addr = 32'h0; bus_p.we = 1'b0; bus_p.req = 1'b1;
        #1;
        chk("p_rst_gnt", {31'd0, bus_p.gnt}, 32'd1);
        @(posedge clk); #1;
        bus_p.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        rv_before = p_rv_cnt;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("p_no_rvalid_after_reset", p_rv_cnt - rv_before, 32'd0);
        chk("p_out_after_reset", {30'd0, out_p}, 32'd0);

        // Memory contents survive reset.
        a_xfer(1'b0, 32'h10, 4'h0, 32'h0, 32'hCAFEBABE, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("a_post_reset_responses", q_a.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
